// File: rtl/task_dispatcher_fsm.sv
// Sequential task dispatcher: walks a frame's object list, starts the enabled
// units per object, tracks their completions, then waits on depth and swaps.
module task_dispatcher_fsm #(
  parameter int unsigned UNITS = 16,
  parameter int unsigned OBJ_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic [OBJ_W-1:0] object_count,
  input  logic [UNITS-1:0] unit_enable,
  input  logic             abort,
  output logic             next_object,
  input  logic             obj_valid,
  output logic [UNITS-1:0] unit_start,
  input  logic [UNITS-1:0] task_complete,
  input  logic             depth_comparator_write_complete,
  output logic             tasks_complete,
  output logic             busy,
  output logic [OBJ_W-1:0] object_index
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DISPATCH,
    WAIT_UNITS,
    DRAIN,
    SWAP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [OBJ_W-1:0] count_q;
  logic [UNITS-1:0] enable_q;
  logic [UNITS-1:0] done_q;
  logic [UNITS-1:0] done_seen;
  logic             units_done;
  logic             last_obj;

  // A completion arriving on the exit-check cycle counts immediately.
  assign done_seen  = done_q | (task_complete & enable_q);
  assign units_done = (done_seen == enable_q);
  assign last_obj   = (object_index == count_q - OBJ_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (frame_start) state_nxt = (object_count == '0) ? DRAIN : FETCH;
      FETCH:      if (obj_valid) state_nxt = DISPATCH;
      DISPATCH:   state_nxt = WAIT_UNITS;
      WAIT_UNITS: if (units_done) state_nxt = last_obj ? DRAIN : FETCH;
      DRAIN:      if (depth_comparator_write_complete) state_nxt = SWAP;
      SWAP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE)) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q      <= '0;
      enable_q     <= '0;
      done_q       <= '0;
      object_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            count_q      <= object_count;
            enable_q     <= unit_enable;
            object_index <= '0;
          end
        end
        DISPATCH: done_q <= '0;
        WAIT_UNITS: begin
          done_q <= done_seen;
          if (units_done && !last_obj && !abort) object_index <= object_index + OBJ_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign next_object    = (state == FETCH);
  assign unit_start     = (state == DISPATCH) ? enable_q : '0;
  assign tasks_complete = (state == SWAP);
  assign busy           = (state != IDLE);

endmodule
